// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_dot_sequencer
// Brief    : Frames a stream of signed operand pairs into one dot-product job
//            for a single MAC accumulator cell and returns the settled sum.
// Revision : 1.0  initial release
// ============================================================================
module mac_dot_sequencer #(
    parameter  int N       = 32,
    parameter  int MAX_LEN = 256,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic          in_last,
    output logic          mac_clr,
    output logic          mac_en,
    output logic [N-1:0]  mac_a,
    output logic [N-1:0]  mac_b,
    input  logic [N-1:0]  mac_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic [CW-1:0] res_count,
    output logic          res_trunc
);

    localparam logic [CW-1:0] C_MAX_LEN = CW'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN1 = 3'd3,
        S_DRAIN2 = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_trunc;
    logic          r_mac_clr;
    logic          r_mac_en;
    logic [N-1:0]  r_mac_a;
    logic [N-1:0]  r_mac_b;
    logic          r_res_valid;
    logic [N-1:0]  r_res_data;
    logic [CW-1:0] r_res_count;
    logic          r_res_trunc;

    logic          w_in_ready;
    logic          w_accept;
    logic [CW-1:0] w_count_nxt;

    assign w_in_ready  = (r_state == S_RUN);
    assign w_accept    = in_valid & w_in_ready;
    assign w_count_nxt = r_count + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_trunc     <= 1'b0;
            r_mac_clr   <= 1'b1;
            r_mac_en    <= 1'b0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_count <= '0;
            r_res_trunc <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mac_en  <= 1'b0;
                    r_mac_clr <= in_valid;
                    if (in_valid) begin
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_mac_clr <= 1'b0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    r_mac_en <= w_accept;
                    if (w_accept) begin
                        r_mac_a <= in_a;
                        r_mac_b <= in_b;
                        r_count <= w_count_nxt;
                        // in_last wins over the length limit, so trunc stays 0
                        if (in_last) begin
                            r_state <= S_DRAIN1;
                        end else if (w_count_nxt == C_MAX_LEN) begin
                            r_trunc <= 1'b1;
                            r_state <= S_DRAIN1;
                        end
                    end
                end
                S_DRAIN1: begin
                    r_mac_en <= 1'b0;
                    r_state  <= S_DRAIN2;
                end
                S_DRAIN2: begin
                    // MAC absorbed the final product on the previous edge
                    r_res_data  <= mac_out;
                    r_res_count <= r_count;
                    r_res_trunc <= r_trunc;
                    r_res_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_count     <= '0;
                        r_trunc     <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign mac_clr   = r_mac_clr;
    assign mac_en    = r_mac_en;
    assign mac_a     = r_mac_a;
    assign mac_b     = r_mac_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_count = r_res_count;
    assign res_trunc = r_res_trunc;

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_dot_sequencer
// Brief    : Directed bench for mac_dot_sequencer with a behavioural MAC cell.
// Revision : 1.0  initial release
// ============================================================================
module tb_mac_dot_sequencer;

    localparam int N       = 32;
    localparam int MAX_LEN = 4;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic          in_last = 1'b0;
    logic          mac_clr;
    logic          mac_en;
    logic [N-1:0]  mac_a;
    logic [N-1:0]  mac_b;
    logic [N-1:0]  mac_out;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [N-1:0]  res_data;
    logic [CW-1:0] res_count;
    logic          res_trunc;

    int errors = 0;
    int checks = 0;
    int en_cycles = 0;
    int clr_cycles = 0;

    mac_dot_sequencer #(.N(N), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
        .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_count(res_count), .res_trunc(res_trunc)
    );

    always #5 clk = ~clk;

    // Accumulator cell: wrap-around sum of N-bit products
    logic [N-1:0] acc = '0;
    always @(posedge clk) begin
        if (mac_clr)     acc <= '0;
        else if (mac_en) acc <= acc + N'(mac_a * mac_b);
    end
    assign mac_out = acc;

    always @(posedge clk) begin
        if (mac_en)  en_cycles  <= en_cycles + 1;
        if (mac_clr) clr_cycles <= clr_cycles + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait for in_ready, then let the accepting edge pass
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        while (in_ready !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        tick;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_timeout: res_valid=%b required 1", res_valid);
        end
    endtask

    task automatic take_result;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL res_release: res_valid=%b required 0", res_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if (mac_clr !== 1'b1) begin errors++; $display("FAIL rst_mac_clr: got %b required 1", mac_clr); end
        checks++;
        if ({in_ready, mac_en, res_valid, res_trunc} !== 4'b0) begin
            errors++; $display("FAIL rst_flags: got %b required 0000", {in_ready, mac_en, res_valid, res_trunc});
        end
        checks++;
        if ({mac_a, mac_b, res_data, res_count} !== '0) begin
            errors++; $display("FAIL rst_data: mac_a=%h mac_b=%h res_data=%h res_count=%0d required 0", mac_a, mac_b, res_data, res_count);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (mac_clr !== 1'b0) begin errors++; $display("FAIL rst_release_clr: got %b required 0", mac_clr); end
    endtask

    task automatic test_basic;
        int en0, clr0, n;
        en0 = en_cycles; clr0 = clr_cycles;
        res_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'd1; in_b = 32'd4;
        tick;
        checks++;
        if (mac_clr !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_clear: mac_clr=%b in_ready=%b required 1/0", mac_clr, in_ready);
        end
        send(32'd1, 32'd4, 1'b0);
        checks++;
        if (mac_en !== 1'b1 || mac_a !== 32'd1 || mac_b !== 32'd4) begin
            errors++; $display("FAIL basic_feed: mac_en=%b mac_a=%0d mac_b=%0d required 1/1/4", mac_en, mac_a, mac_b);
        end
        send(32'd2, 32'd5, 1'b0);
        send(32'd3, 32'd6, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_drain_ready: got %b required 0", in_ready); end
        wait_result(n);
        checks++;
        if (n != 2) begin errors++; $display("FAIL basic_latency: got %0d required 2", n); end
        checks++;
        if (res_data !== 32'd32 || res_count !== 3'd3 || res_trunc !== 1'b0) begin
            errors++; $display("FAIL basic_result: data=%0d count=%0d trunc=%b required 32/3/0", res_data, res_count, res_trunc);
        end
        tick;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_release: res_valid=%b required 0", res_valid); end
        checks++;
        if (en_cycles - en0 != 3 || clr_cycles - clr0 != 1) begin
            errors++; $display("FAIL basic_pulses: en=%0d clr=%0d required 3/1", en_cycles - en0, clr_cycles - clr0);
        end
    endtask

    task automatic test_gap_backpressure;
        int n;
        send(-32'sd7, 32'd2, 1'b0);
        tick;
        checks++;
        if (mac_en !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL gap_en: mac_en=%b in_ready=%b required 0/1", mac_en, in_ready);
        end
        tick;
        checks++;
        if (mac_a !== -32'sd7 || mac_b !== 32'd2) begin
            errors++; $display("FAIL gap_hold: mac_a=%h mac_b=%h required fffffff9/2", mac_a, mac_b);
        end
        send(32'd3, 32'd5, 1'b1);
        wait_result(n);
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (res_valid !== 1'b1 || res_data !== 32'h1 || res_count !== 3'd2 || res_trunc !== 1'b0) begin
                errors++; $display("FAIL gap_hold_result[%0d]: valid=%b data=%h count=%0d trunc=%b required 1/00000001/2/0", i, res_valid, res_data, res_count, res_trunc);
            end
        end
        take_result;
    endtask

    task automatic test_truncation;
        int en0, n;
        en0 = en_cycles;
        for (int i = 0; i < 4; i++) send(32'd1, 32'd1, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL trunc_ready: got %b required 0", in_ready); end
        in_valid = 1'b1;  // beats 5 and 6 stay pending upstream
        wait_result(n);
        tick;
        checks++;
        if (res_data !== 32'd4 || res_count !== 3'd4 || res_trunc !== 1'b1) begin
            errors++; $display("FAIL trunc_result: data=%0d count=%0d trunc=%b required 4/4/1", res_data, res_count, res_trunc);
        end
        checks++;
        if (en_cycles - en0 != 4) begin errors++; $display("FAIL trunc_beats: got %0d required 4", en_cycles - en0); end
        in_valid = 1'b0;
        take_result;
        for (int i = 0; i < 3; i++) send(32'd1, 32'd1, 1'b0);
        send(32'd1, 32'd1, 1'b1);
        wait_result(n);
        checks++;
        if (res_data !== 32'd4 || res_count !== 3'd4 || res_trunc !== 1'b0) begin
            errors++; $display("FAIL last_at_max: data=%0d count=%0d trunc=%b required 4/4/0", res_data, res_count, res_trunc);
        end
        take_result;
    endtask

    task automatic test_wrap;
        int n;
        send(32'h0001_0000, 32'h0001_0000, 1'b0);
        send(32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_result(n);
        checks++;
        if (res_data !== 32'd0 || res_count !== 3'd2 || res_trunc !== 1'b0) begin
            errors++; $display("FAIL wrap: data=%h count=%0d trunc=%b required 0/2/0", res_data, res_count, res_trunc);
        end
        take_result;
    endtask

    task automatic test_reset_mid_job;
        int n;
        send(32'd9, 32'd9, 1'b0);
        send(32'd9, 32'd9, 1'b0);
        rst = 1'b1;
        tick;
        checks++;
        if (mac_clr !== 1'b1 || in_ready !== 1'b0 || res_valid !== 1'b0 || mac_en !== 1'b0) begin
            errors++; $display("FAIL midrst_state: clr=%b ready=%b valid=%b en=%b required 1/0/0/0", mac_clr, in_ready, res_valid, mac_en);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_result[%0d]: got %b required 0", i, res_valid); end
        end
        send(32'd2, 32'd3, 1'b1);
        wait_result(n);
        checks++;
        if (res_data !== 32'd6 || res_count !== 3'd1 || res_trunc !== 1'b0) begin
            errors++; $display("FAIL midrst_next_job: data=%0d count=%0d trunc=%b required 6/1/0", res_data, res_count, res_trunc);
        end
        take_result;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_gap_backpressure;
        test_truncation;
        test_wrap;
        test_reset_mid_job;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
